gate_truth_checker: RTL and testbench
=====================================

Name: gate_truth_checker

Overview:
- Self-checking exerciser for 2..4-input combinational gate models, such as the switch-level NAND cell.
- Sits directly upstream and downstream of the gate under test. It drives every input combination in ascending order, holds each combination for a settle window, samples the gate output and compares it against a parameterised truth table.
- Reports a pass/fail verdict, the mismatch count and the first failing vector. This replaces hand-written delay-sequenced stimulus for gate cells.

Parameters:
- N_IN, 2, number of gate inputs (legal 2..4); vector count NV = 2**N_IN.
- HOLD_CYCLES, 4, cycles a vector is held before the sample cycle (legal >= 1).
- EXPECT, 4'b0111, truth table; bit i is the expected output for input vector i. Width NV. Default is NAND2: index {a,b}, a is the MSB.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin a run; sampled only in IDLE or DONE
- in_vec  output  N_IN  drives the gate inputs; bit N_IN-1 maps to gate input a, bit 0 to the last input
- f  input  1  gate output under test
- busy  output  1  high from start acceptance until DONE entry
- done  output  1  high while in DONE (level, sticky until next start or rst)
- pass  output  1  valid only when done; 1 iff err_count == 0
- err_count  output  N_IN+1  number of mismatching vectors in the current or last run
- fail_valid  output  1  a mismatch has been recorded this run
- fail_vec  output  N_IN  first mismatching vector; 0 when fail_valid=0

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, ports named clk and rst.
- Reset (rst high at an edge) gives: state=IDLE, in_vec=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0, hold counter=0.
  - rst has priority over all other inputs.
  - rst mid-run aborts immediately; no partial verdict is kept.
- States: IDLE, DRIVE, SAMPLE, DONE. All outputs are registered.
- IDLE:
  - start=1 at edge k -> DRIVE at edge k.
  - At that edge: in_vec=0, cnt=0, busy=1, done=0, err_count=0, fail_valid=0, fail_vec=0.
- DRIVE:
  - in_vec is stable and cnt increments each edge.
  - When cnt == HOLD_CYCLES-1 -> SAMPLE.
  - Stays exactly HOLD_CYCLES cycles.
- SAMPLE, at the edge leaving this state:
  - Compare f with EXPECT[in_vec]. Any value other than the expected 0/1, including X or Z, is a mismatch.
  - On mismatch: err_count += 1. If fail_valid==0, set fail_valid=1 and fail_vec=in_vec.
  - If in_vec == NV-1 -> DONE (busy=0, done=1, pass=(final err_count==0)).
  - Otherwise in_vec += 1, cnt=0 -> DRIVE.
- Timing:
  - Each vector occupies HOLD_CYCLES+1 cycles and is stable for that whole span before f is sampled.
  - done rises at edge k + NV*(HOLD_CYCLES+1). For the defaults that is k+20.
- DONE:
  - Outputs hold.
  - in_vec holds NV-1.
  - start=1 restarts exactly as from IDLE.
- start while busy (DRIVE/SAMPLE) is ignored, with no effect on counters or timing.
- Width: err_count never exceeds NV, so N_IN+1 bits need no saturation.
- The in_vec increment never wraps inside a run, because the last vector exits to DONE.

Decomposition:
- Shared include gate_check_defs.vh holds:
  - state encodings: IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, DONE=2'd3;
  - truth-table constants TT_NAND2=4'b0111, TT_NOR2=4'b0001, TT_AND2=4'b1000, TT_OR2=4'b1110, TT_XOR2=4'b0110.
- One sub-module is natural: settle_timer.
  - Parameter HOLD_CYCLES.
  - Inputs clk, rst, clr, en; output expired.
  - Owns the hold counter.
- FSM, vector register and scoreboard stay in the top level.

Test Plan:
- Defaults, NAND2 model on f, start pulse at cycle 2:
  - in_vec steps 0,1,2,3, each held 5 cycles;
  - done=1 at cycle 22, pass=1, err_count=0, fail_valid=0.
- EXPECT=TT_NAND2 with AND2 model on f:
  - err_count=4, fail_valid=1, fail_vec=2'b00, pass=0.
- NAND2 model with output stuck at 1:
  - err_count=1, fail_vec=2'b11, pass=0.
- f tied to 1'bz:
  - err_count=4, fail_vec=0, pass=0.
- Restart mid-run:
  - Assert rst during vector 2 -> all outputs 0 and state IDLE on the next edge.
  - Then start -> full clean run with pass=1.
- HOLD_CYCLES=1; start re-pulsed during DRIVE of vector 1, then start pulsed in DONE:
  - Mid-run pulse is ignored; done at k+8.
  - Pulse in DONE restarts, clearing done and err_count at that edge.

Source files
------------

// File: rtl/gate_truth_checker_pkg.sv
// Shared state encodings and reference truth tables for the gate exerciser.
// Truth-table bit i is the expected gate output for input vector i.
package gate_truth_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] TT_NAND2 = 4'b0111;
    localparam logic [3:0] TT_NOR2  = 4'b0001;
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;

endpackage

// File: rtl/gate_truth_checker_settle_timer.sv
// Hold counter that measures how long a vector has been driven onto the gate.
// It stops at the terminal count, so expired stays high until the next clr.
module gate_truth_checker_settle_timer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] TC  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + ONE;
        end
    end

    assign expired = (cnt == TC);

endmodule

// File: rtl/gate_truth_checker.sv
// Walks every input vector of an N_IN-input gate, holds each for a settle
// window, then samples f against EXPECT and keeps a pass/fail scoreboard.
module gate_truth_checker
    import gate_truth_checker_pkg::*;
#(
    parameter int N_IN        = 2,
    parameter int HOLD_CYCLES = 4,
    parameter logic [(1 << N_IN)-1:0] EXPECT = TT_NAND2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] in_vec,
    input  logic            f,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] fail_vec
);

    localparam int NV = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NV - 1);
    localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
    localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);

    state_t            state, state_nxt;
    logic [N_IN-1:0]   in_vec_nxt, fail_vec_nxt;
    logic [N_IN:0]     err_count_nxt;
    logic              busy_nxt, done_nxt, pass_nxt, fail_valid_nxt;
    logic              timer_clr, timer_en, expired, mismatch;

    gate_truth_checker_settle_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_settle_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            in_vec     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else begin
            state      <= state_nxt;
            in_vec     <= in_vec_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            pass       <= pass_nxt;
            err_count  <= err_count_nxt;
            fail_valid <= fail_valid_nxt;
            fail_vec   <= fail_vec_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        in_vec_nxt     = in_vec;
        busy_nxt       = busy;
        done_nxt       = done;
        pass_nxt       = pass;
        err_count_nxt  = err_count;
        fail_valid_nxt = fail_valid;
        fail_vec_nxt   = fail_vec;
        timer_clr      = 1'b0;
        timer_en       = 1'b0;
        // Case-inequality so an X or Z from the cell never counts as a match.
        mismatch       = (f !== EXPECT[in_vec]);

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt      = ST_DRIVE;
                    in_vec_nxt     = '0;
                    busy_nxt       = 1'b1;
                    done_nxt       = 1'b0;
                    pass_nxt       = 1'b0;
                    err_count_nxt  = '0;
                    fail_valid_nxt = 1'b0;
                    fail_vec_nxt   = '0;
                    timer_clr      = 1'b1;
                end
            end
            ST_DRIVE: begin
                timer_en = 1'b1;
                if (expired) begin
                    state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    err_count_nxt = err_count + ERR_ONE;
                    if (!fail_valid) begin
                        fail_valid_nxt = 1'b1;
                        fail_vec_nxt   = in_vec;
                    end
                end
                if (in_vec == LAST_VEC) begin
                    state_nxt = ST_DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    pass_nxt  = (err_count_nxt == '0);
                end else begin
                    state_nxt  = ST_DRIVE;
                    in_vec_nxt = in_vec + VEC_ONE;
                    timer_clr  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench: default checker (HOLD_CYCLES=4) and a HOLD_CYCLES=1 copy,
// each fed by a selectable gate model.
module tb_gate_truth_checker;
    import gate_truth_checker_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    int         mode;
    logic [1:0] in_vec_a, in_vec_b, fail_vec_a, fail_vec_b;
    logic [2:0] err_a, err_b;
    logic       f_a, f_b;
    logic       busy_a, done_a, pass_a, fv_a;
    logic       busy_b, done_b, pass_b, fv_b;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    // 0 NAND2, 1 AND2, 2 output stuck at 1, 3 floating output
    function automatic logic gate_model(input logic [1:0] v, input int m);
        case (m)
            0:       return ~(v[1] & v[0]);
            1:       return v[1] & v[0];
            2:       return 1'b1;
            default: return 1'bz;
        endcase
    endfunction

    assign f_a = gate_model(in_vec_a, mode);
    assign f_b = gate_model(in_vec_b, mode);

    gate_truth_checker dut_a (
        .clk (clk), .rst (rst), .start (start_a), .in_vec (in_vec_a), .f (f_a),
        .busy (busy_a), .done (done_a), .pass (pass_a), .err_count (err_a),
        .fail_valid (fv_a), .fail_vec (fail_vec_a)
    );

    gate_truth_checker #(.HOLD_CYCLES(1)) dut_b (
        .clk (clk), .rst (rst), .start (start_b), .in_vec (in_vec_b), .f (f_b),
        .busy (busy_b), .done (done_b), .pass (pass_b), .err_count (err_b),
        .fail_valid (fv_b), .fail_vec (fail_vec_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulses start_a; returns the edge count from acceptance until done is seen.
    task automatic run_a(output int lat);
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        lat = 0;
        while (!done_a && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_verdict_a(input string tag, input int err, input logic fv,
                                   input logic [1:0] fvec, input logic ps);
        check({tag, "_err"}, 32'(err_a), 32'(err));
        check({tag, "_fv"}, 32'(fv_a), 32'(fv));
        check({tag, "_fvec"}, 32'(fail_vec_a), 32'(fvec));
        check({tag, "_pass"}, 32'(pass_a), 32'(ps));
        check({tag, "_done"}, 32'(done_a), 32'd1);
        check({tag, "_busy"}, 32'(busy_a), 32'd0);
    endtask

    initial begin
        int lat;
        int exp_err;
        logic [1:0] first_bad;
        logic fz;

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; mode = 0;
        repeat (3) @(negedge clk);
        check("rst_in_vec", 32'(in_vec_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_pass", 32'(pass_a), 0);
        check("rst_err", 32'(err_a), 0);
        check("rst_fv", 32'(fv_a), 0);
        check("rst_fvec", 32'(fail_vec_a), 0);
        check("rst_b_done", 32'(done_b), 0);
        rst = 1'b0;

        // Clean NAND2 run: vector j/5 is driven after edge k+j, done at k+20
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        for (int j = 0; j < 20; j++) begin
            check($sformatf("seq_vec_%0d", j), 32'(in_vec_a), 32'(j / 5));
            check($sformatf("seq_done_%0d", j), 32'(done_a), 0);
            check($sformatf("seq_busy_%0d", j), 32'(busy_a), 1);
            @(negedge clk);
        end
        check("nand_in_vec_last", 32'(in_vec_a), 3);
        check_verdict_a("nand", 0, 1'b0, 2'b00, 1'b1);
        repeat (3) @(negedge clk);
        check("nand_hold_done", 32'(done_a), 1);
        check("nand_hold_vec", 32'(in_vec_a), 3);

        mode = 1;
        run_a(lat);
        check("and_lat", 32'(lat), 20);
        check_verdict_a("and", 4, 1'b1, 2'b00, 1'b0);

        mode = 2;
        run_a(lat);
        check("stuck1_lat", 32'(lat), 20);
        check_verdict_a("stuck1", 1, 1'b1, 2'b11, 1'b0);

        // Floating output: every vector whose model value differs from NAND2
        mode = 3;
        exp_err = 0;
        first_bad = 2'b00;
        for (int i = 3; i >= 0; i--) begin
            fz = gate_model(2'(i), 3);
            if (fz !== TT_NAND2[i]) begin
                exp_err++;
                first_bad = 2'(i);
            end
        end
        run_a(lat);
        check("float_lat", 32'(lat), 20);
        check_verdict_a("float", exp_err, 1'b1, first_bad, 1'b0);

        // Reset during vector 2 aborts with no verdict left behind
        mode = 0;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        repeat (11) @(negedge clk);
        check("abort_at_vec2", 32'(in_vec_a), 2);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("abort_in_vec", 32'(in_vec_a), 0);
        check("abort_busy", 32'(busy_a), 0);
        check("abort_done", 32'(done_a), 0);
        check("abort_err", 32'(err_a), 0);
        check("abort_fv", 32'(fv_a), 0);
        repeat (3) @(negedge clk);
        check("abort_stays_idle", 32'(busy_a), 0);
        run_a(lat);
        check("rerun_lat", 32'(lat), 20);
        check_verdict_a("rerun", 0, 1'b0, 2'b00, 1'b1);

        // HOLD_CYCLES=1 with AND2 model: start re-pulsed while vector 1 drives
        mode = 1;
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("h1_vec1", 32'(in_vec_b), 1);
        start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        lat = 3;
        while (!done_b && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("h1_lat", 32'(lat), 8);
        check("h1_err", 32'(err_b), 4);
        check("h1_fvec", 32'(fail_vec_b), 0);
        check("h1_pass", 32'(pass_b), 0);

        // Start while in DONE restarts and clears the scoreboard at that edge
        mode = 0;
        start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        check("h1_restart_done", 32'(done_b), 0);
        check("h1_restart_busy", 32'(busy_b), 1);
        check("h1_restart_err", 32'(err_b), 0);
        check("h1_restart_fv", 32'(fv_b), 0);
        check("h1_restart_vec", 32'(in_vec_b), 0);
        lat = 0;
        while (!done_b && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("h1_restart_lat", 32'(lat), 8);
        check("h1_restart_pass", 32'(pass_b), 1);
        check("h1_restart_err_end", 32'(err_b), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
